// File: rtl/kgp_rf_pkg.sv
// Shared defaults and helpers for the KGP-RISC multi-port register bank.
package kgp_rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int ADDR_MAX   = 16;
  localparam int NUM_RD_MAX = 4;
  localparam int BUS_MAX    = ADDR_MAX * NUM_RD_MAX;

  // Port k's address from a flattened bus of w-bit fields (zero-extended to ADDR_MAX).
  function automatic logic [ADDR_MAX-1:0] rd_slice(input logic [BUS_MAX-1:0] bus,
                                                   input int k, input int w);
    logic [BUS_MAX-1:0] sh;
    sh = (bus >> (k * w)) & ((BUS_MAX'(1) << w) - BUS_MAX'(1));
    return ADDR_MAX'(sh);
  endfunction
endpackage

// File: rtl/kgp_rf_read_port.sv
// One read port: decode, write bypass and zero-register override.
module kgp_rf_read_port
  import kgp_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic [DEPTH*DATA_W-1:0] regs_flat,
  input  logic [DEPTH-1:0]        busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_busy
);
  logic is_zero, hit;

  assign is_zero = ZERO_REG && (rd_addr == ADDR_W'(ZERO_ADDR));
  assign hit     = BYPASS && wr_en && (wr_addr == rd_addr);

  always_comb begin
    rd_data = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
    rd_busy = busy[rd_addr];
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (hit) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
  end
endmodule

// File: rtl/kgp_regfile_mp.sv
// Multi-read-port register bank with write bypass and busy scoreboard.
module kgp_regfile_mp
  import kgp_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rsv_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH*DATA_W-1:0]      regs_flat;
  logic [DEPTH-1:0]             busy;
  logic                         wr_ok, rsv_ok, conflict_c;

  assign wr_ok  = wr_en  && !(ZERO_REG && wr_addr  == ADDR_W'(ZERO_ADDR));
  assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == ADDR_W'(ZERO_ADDR));
  // A write retiring the same register this edge frees it, so re-reserving is not a conflict.
  assign conflict_c = rsv_ok && busy[rsv_addr] && !(wr_ok && wr_addr == rsv_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs         <= '0;
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      // Later assignment: a same-edge reservation outranks the write's clear.
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
      rsv_conflict <= conflict_c;
    end
  end

  assign regs_flat = regs;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = ADDR_W'(rd_slice(BUS_MAX'(rd_addr), k, ADDR_W));

    kgp_rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .regs_flat(regs_flat),
      .busy     (busy),
      .wr_en    (wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (port_addr),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_kgp_regfile_mp.sv
// Bench for kgp_regfile_mp: directed vector table, corner sequences, random vs. model.
module tb_kgp_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rsv_en;
  logic [4:0]  wr_addr, rsv_addr, ra0, ra1;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic        rsv_conflict, nb_rsv_conflict;

  int n_chk = 0;
  int n_fail = 0;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  kgp_regfile_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rsv_conflict(rsv_conflict)
  );

  kgp_regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .rsv_conflict(nb_rsv_conflict)
  );

  // Reference model: architectural state following the bank's rules.
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic        m_conf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_rd(input logic [4:0] a, input bit byp,
                                 output logic [31:0] d, output logic b);
    if (a == 5'd0) begin
      d = 32'd0; b = 1'b0;
    end else if (byp && wr_en && wr_addr == a) begin
      d = wr_data; b = 1'b0;
    end else begin
      d = m_regs[a]; b = m_busy[a];
    end
  endfunction

  // Advance one edge and apply the same rules to the model.
  task automatic tick();
    bit wz, rz;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_conf = 1'b0;
    end else begin
      wz = wr_en && wr_addr != 5'd0;
      rz = rsv_en && rsv_addr != 5'd0;
      m_conf = rz && m_busy[rsv_addr] && !(wz && wr_addr == rsv_addr);
      if (wz) begin m_regs[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
      if (rz) m_busy[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] d; logic b;
    exp_rd(ra0, 1'b1, d, b); chk({tag, " d0"}, rd_data[31:0], d);  chk({tag, " b0"}, {31'd0, rd_busy[0]}, {31'd0, b});
    exp_rd(ra1, 1'b1, d, b); chk({tag, " d1"}, rd_data[63:32], d); chk({tag, " b1"}, {31'd0, rd_busy[1]}, {31'd0, b});
    exp_rd(ra0, 1'b0, d, b); chk({tag, " nb d0"}, nb_rd_data[31:0], d);  chk({tag, " nb b0"}, {31'd0, nb_rd_busy[0]}, {31'd0, b});
    exp_rd(ra1, 1'b0, d, b); chk({tag, " nb d1"}, nb_rd_data[63:32], d); chk({tag, " nb b1"}, {31'd0, nb_rd_busy[1]}, {31'd0, b});
    chk({tag, " conf"}, {31'd0, rsv_conflict}, {31'd0, m_conf});
    chk({tag, " nb conf"}, {31'd0, nb_rsv_conflict}, {31'd0, m_conf});
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      ra0      = 5'($urandom_range(0, 7));
      ra1      = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #2;
      chk_model("rand");
      tick();
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1, nd0, nd1;
    logic        b0, b1, nb0, nb1, cf;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic re, logic [4:0] ra,
                              logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] d0, logic b0, logic [31:0] d1, logic b1,
                              logic [31:0] nd0, logic nb0, logic [31:0] nd1, logic nb1, logic cf);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
    v.nd0 = nd0; v.nb0 = nb0; v.nd1 = nd1; v.nb1 = nb1; v.cf = cf;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 28, 143434,       0, 0, 1,  2,  0, 0, 0, 0,                       0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0,  0,            0, 0, 28, 30, 143434, 0, 0, 0,                  143434, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  0,            0, 0, 30, 28, 0, 0, 143434, 0,                  0, 0, 143434, 0, 0);
    tbl[3]  = mk(1, 7,  32'hDEADBEEF, 0, 0, 28, 7,  143434, 0, 32'hDEADBEEF, 0,       143434, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0,  0,            1, 5, 5,  7,  0, 0, 32'hDEADBEEF, 0,            0, 0, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(0, 0,  0,            1, 5, 5,  7,  0, 1, 32'hDEADBEEF, 0,            0, 1, 32'hDEADBEEF, 0, 0);
    tbl[6]  = mk(0, 0,  0,            0, 0, 5,  7,  0, 1, 32'hDEADBEEF, 0,            0, 1, 32'hDEADBEEF, 0, 1);
    tbl[7]  = mk(1, 5,  5,            0, 0, 5,  9,  5, 0, 0, 0,                       0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 9,  12,           1, 9, 5,  9,  5, 0, 12, 0,                      5, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0,  0,            0, 0, 5,  9,  5, 0, 12, 1,                      5, 0, 12, 1, 0);
    tbl[10] = mk(1, 0,  55,           1, 0, 0,  9,  0, 0, 12, 1,                      0, 0, 12, 1, 0);
    tbl[11] = mk(0, 0,  0,            1, 3, 0,  3,  0, 0, 0, 0,                       0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0,  0,            0, 0, 0,  3,  0, 0, 0, 1,                       0, 0, 0, 1, 0);

    idle(); ra0 = '0; ra1 = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Random traffic, then a single-edge reset must clear everything.
    rand_cycles(150);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd6;
    rst = 1'b0;
    tick();
    rst = 1'b1; idle();
    for (int a = 0; a < 8; a++) begin
      ra0 = 5'(a); ra1 = 5'(a + 8);
      #1;
      chk("rst d0", rd_data[31:0], 32'd0);  chk("rst d1", rd_data[63:32], 32'd0);
      chk("rst busy", {30'd0, rd_busy}, 32'd0);
      chk("rst conf", {31'd0, rsv_conflict}, 32'd0);
    end
    tick();

    for (int i = 0; i < 13; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rsv_en = tbl[i].re; rsv_addr = tbl[i].ra; ra0 = tbl[i].r0; ra1 = tbl[i].r1;
      #2;
      chk($sformatf("vec%0d d0", i), rd_data[31:0], tbl[i].d0);
      chk($sformatf("vec%0d b0", i), {31'd0, rd_busy[0]}, {31'd0, tbl[i].b0});
      chk($sformatf("vec%0d d1", i), rd_data[63:32], tbl[i].d1);
      chk($sformatf("vec%0d b1", i), {31'd0, rd_busy[1]}, {31'd0, tbl[i].b1});
      chk($sformatf("vec%0d nb d0", i), nb_rd_data[31:0], tbl[i].nd0);
      chk($sformatf("vec%0d nb b0", i), {31'd0, nb_rd_busy[0]}, {31'd0, tbl[i].nb0});
      chk($sformatf("vec%0d nb d1", i), nb_rd_data[63:32], tbl[i].nd1);
      chk($sformatf("vec%0d nb b1", i), {31'd0, nb_rd_busy[1]}, {31'd0, tbl[i].nb1});
      chk($sformatf("vec%0d conf", i), {31'd0, rsv_conflict}, {31'd0, tbl[i].cf});
      tick();
    end

    // Mid-operation reset with r3 reserved; a write during reset is dropped.
    idle(); ra0 = 5'd28; ra1 = 5'd3;
    #1;
    chk("pre-rst r3 busy", {31'd0, rd_busy[1]}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd28; wr_data = 32'd77; rsv_en = 1'b1; rsv_addr = 5'd3;
    rst = 1'b0;
    tick();
    idle();
    #1;
    chk("in-rst r3 busy", {31'd0, rd_busy[1]}, 32'd0);
    chk("in-rst r28", rd_data[31:0], 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post-rst r3 d", rd_data[63:32], 32'd0);
    chk("post-rst r3 busy", {31'd0, rd_busy[1]}, 32'd0);
    chk("post-rst r28 nb", nb_rd_data[31:0], 32'd0);
    chk("post-rst conf", {31'd0, rsv_conflict}, 32'd0);

    rand_cycles(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
